// File: rtl/bcd_pkg.sv
// Shared BCD types and constants for the binary-to-BCD converter and its
// downstream BCD arithmetic.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_ADJ_THRESH = 4'd5;
    localparam bcd_digit_t BCD_ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bin2bcd_state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a digit of 5..9 gets +3 so that the
// following left shift carries into the next decade.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit,
    output bcd_digit_t adj
);

    // Work digits stay in 0..9, so the corrected value is at most 12 and
    // the 4-bit sum never wraps.
    assign adj = (digit >= BCD_ADJ_THRESH) ? bcd_digit_t'(digit + BCD_ADJ_ADD) : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with a start/busy/done handshake and a sticky overflow flag.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int W = 8,
    parameter int D = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [4*D-1:0]   bcd,
    output logic             overflow
);

    localparam int            CW        = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    bin2bcd_state_t state_q;
    logic [W-1:0]   shift_q;
    logic [4*D-1:0] digits_q;
    logic [CW-1:0]  cnt_q;
    logic           sticky_q;

    logic [4*D-1:0] digits_adj;
    logic [4*D-1:0] digits_next;
    logic [W-1:0]   shift_next;
    logic           carry_out;

    for (genvar i = 0; i < D; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit (digits_q[4*i +: 4]),
            .adj   (digits_adj[4*i +: 4])
        );
    end

    // The bit leaving the top digit is the part of the value that does not
    // fit in D digits; losing it leaves the value mod 10^D in the digits.
    assign {carry_out, digits_next, shift_next} = {digits_adj, shift_q, 1'b0};

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register reading the
        // pre-edge values, so the order of statements below does not matter.
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            digits_q <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q  <= bin;
                        digits_q <= '0;
                        cnt_q    <= '0;
                        sticky_q <= 1'b0;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    digits_q <= digits_next;
                    shift_q  <= shift_next;
                    cnt_q    <= cnt_q + 1'b1;
                    sticky_q <= sticky_q | carry_out;
                    // Publish the post-iteration digits directly so the
                    // result lands on the same edge as the last shift.
                    if (cnt_q == LAST_ITER) begin
                        bcd      <= digits_next;
                        overflow <= sticky_q | carry_out;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance, each
// with its own expected-result queue and done-triggered monitor.
module tb_bin2bcd_seq;

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start3 = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  bin3 = '0;
    logic [7:0]  bin2 = '0;
    logic        busy3, done3, ovf3;
    logic        busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;

    exp_t        q3[$];
    exp_t        q2[$];
    int          cyc = 0;
    logic        rst_q = 1'b1;
    int          tests = 0;
    int          failed = 0;
    logic [11:0] last3 = '0;
    logic [7:0]  last2 = '0;
    logic        last_ovf3 = 1'b0;
    logic        last_ovf2 = 1'b0;
    logic        done_prev3 = 1'b0;
    logic        done_prev2 = 1'b0;

    bin2bcd_seq #(.W(8), .D(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .start    (start3),
        .bin      (bin3),
        .busy     (busy3),
        .done     (done3),
        .bcd      (bcd3),
        .overflow (ovf3)
    );

    bin2bcd_seq #(.W(8), .D(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .start    (start2),
        .bin      (bin2),
        .busy     (busy2),
        .done     (done2),
        .bcd      (bcd2),
        .overflow (ovf2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= reset;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [11:0] to_bcd3(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    // Two-digit BCD adder model standing in for the downstream block.
    function automatic logic [8:0] bcd_add2(input logic [7:0] a, input logic [7:0] b);
        int lo, hi, c;
        lo = int'(a[3:0]) + int'(b[3:0]);
        c  = (lo > 9) ? 1 : 0;
        if (c == 1) lo = lo - 10;
        hi = int'(a[7:4]) + int'(b[7:4]) + c;
        c  = (hi > 9) ? 1 : 0;
        if (c == 1) hi = hi - 10;
        return {1'(c), 4'(hi), 4'(lo)};
    endfunction

    // Monitor for the 3-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (rst_q) begin
                last3     = '0;
                last_ovf3 = 1'b0;
            end
            if (done3) begin
                if (q3.size() == 0) begin
                    check("unexpected_done3", 32'(done3), 32'd0);
                end else begin
                    e = q3.pop_front();
                    check("bcd3", 32'(bcd3), 32'(e.bcd));
                    check("ovf3", 32'(ovf3), 32'(e.ovf));
                    check("latency3", 32'(cyc), 32'(e.due));
                end
                check("busy3_in_done", 32'(busy3), 32'd1);
                last3     = bcd3;
                last_ovf3 = ovf3;
            end else begin
                if (done_prev3) check("busy3_after_done", 32'(busy3), 32'd0);
                check("hold3", 32'({ovf3, bcd3}), 32'({last_ovf3, last3}));
            end
            done_prev3 = done3;
        end
    end

    // Monitor for the 2-digit instance.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0) begin
            if (rst_q) begin
                last2     = '0;
                last_ovf2 = 1'b0;
            end
            if (done2) begin
                if (q2.size() == 0) begin
                    check("unexpected_done2", 32'(done2), 32'd0);
                end else begin
                    e = q2.pop_front();
                    check("bcd2", 32'(bcd2), 32'(e.bcd[7:0]));
                    check("ovf2", 32'(ovf2), 32'(e.ovf));
                    check("latency2", 32'(cyc), 32'(e.due));
                end
                last2     = bcd2;
                last_ovf2 = ovf2;
            end else begin
                if (done_prev2) check("busy2_after_done", 32'(busy2), 32'd0);
                check("hold2", 32'({ovf2, bcd2}), 32'({last_ovf2, last2}));
            end
            done_prev2 = done2;
        end
    end

    // Returns just after the accepting edge with the expectation queued.
    task automatic start_conv(input bit sel2, input logic [7:0] v,
                              input logic [11:0] exp_bcd, input logic exp_ovf);
        exp_t e;
        @(negedge clk);
        if (sel2) begin bin2 = v; start2 = 1'b1; end
        else      begin bin3 = v; start3 = 1'b1; end
        @(posedge clk);
        #1;
        e.bcd = exp_bcd;
        e.ovf = exp_ovf;
        e.due = cyc + 8;
        if (sel2) begin q2.push_back(e); start2 = 1'b0; end
        else      begin q3.push_back(e); start3 = 1'b0; end
    endtask

    task automatic wait_idle(input bit sel2);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!(sel2 ? busy2 : busy3)) return;
        end
        check(sel2 ? "timeout_idle2" : "timeout_idle3", 32'd1, 32'd0);
    endtask

    initial begin
        logic [11:0] r47, r38;
        logic        seen;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_busy", 32'(busy3), 32'd0);
        check("reset_done", 32'(done3), 32'd0);
        check("reset_bcd", 32'(bcd3), 32'd0);
        check("reset_ovf", 32'(ovf3), 32'd0);

        // Full-scale input and zero.
        start_conv(1'b0, 8'd255, 12'h255, 1'b0);
        wait_idle(1'b0);
        start_conv(1'b0, 8'd0, 12'h000, 1'b0);
        wait_idle(1'b0);

        // A start pulse three cycles into SHIFT must be ignored.
        start_conv(1'b0, 8'd99, 12'h099, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bin3 = 8'd200; start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        wait_idle(1'b0);
        repeat (12) @(negedge clk);

        // A start pulse during DONE must be ignored as well.
        start_conv(1'b0, 8'd64, 12'h064, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = done3;
        end
        check("done_seen", 32'(seen), 32'd1);
        bin3 = 8'd200; start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        repeat (12) @(negedge clk);
        check("idle_after_done_start", 32'(busy3), 32'd0);

        // Reset in the fourth SHIFT cycle aborts the conversion.
        start_conv(1'b0, 8'd173, 12'h173, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(q3.pop_back());
        check("abort_bcd", 32'(bcd3), 32'd0);
        check("abort_busy", 32'(busy3), 32'd0);
        repeat (12) @(negedge clk);
        start_conv(1'b0, 8'd123, 12'h123, 1'b0);
        wait_idle(1'b0);

        // Two-digit instance: overflow sets, then clears on the next load.
        start_conv(1'b1, 8'd150, 12'h050, 1'b1);
        wait_idle(1'b1);
        start_conv(1'b1, 8'd99, 12'h099, 1'b0);
        wait_idle(1'b1);
        start_conv(1'b1, 8'd255, 12'h055, 1'b1);
        wait_idle(1'b1);
        start_conv(1'b1, 8'd100, 12'h000, 1'b1);
        wait_idle(1'b1);

        // Results feeding the downstream BCD adder.
        start_conv(1'b0, 8'd47, 12'h047, 1'b0);
        wait_idle(1'b0);
        r47 = last3;
        start_conv(1'b0, 8'd38, 12'h038, 1'b0);
        wait_idle(1'b0);
        r38 = last3;
        check("adder_sum", 32'(bcd_add2(r47[7:0], r38[7:0])), 32'h085);

        // Exhaustive sweep of the 3-digit instance.
        for (int v = 0; v < 256; v++) begin
            start_conv(1'b0, 8'(v), to_bcd3(v), 1'b0);
            wait_idle(1'b0);
        end

        repeat (4) @(negedge clk);
        check("q3_drained", 32'(q3.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Iterative shift-and-add-3 (double-dabble) converter: unsigned binary in, packed BCD digits out.
- Sits directly upstream of the team's two-digit BCD adder and supplies its BCD operands.
- One bit per clock; start/busy/done handshake; result held until the next conversion.
- Overflow flag covers parameter choices where D digits cannot hold 2^W-1.

Parameters:
- W, 8, binary input width (>=1).
- D, 3, number of BCD output digits (>=1).
- CW, $clog2(W+1), iteration counter width (derived, not overridable).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- start  in  1  request; accepted only when busy=0.
- bin  in  W  binary operand, sampled on the accepting edge only.
- busy  out  1  high from the edge after acceptance until the return to IDLE.
- done  out  1  one-cycle pulse marking the cycle in which bcd/overflow first show the new result.
- bcd  out  4*D  result; digit i at bits [4i+3:4i], digit 0 is the units digit.
- overflow  out  1  high when the value exceeded 10^D-1; bcd then holds the value mod 10^D.

Behaviour:
- Reset (synchronous, any state): state=IDLE, busy=0, done=0, bcd=0, overflow=0, internal shift/work registers and counter cleared.
- A reset during SHIFT aborts the conversion: no done pulse, outputs return to 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge loads the shift register with bin, clears the work digits, counter, and sticky overflow bit, and moves to SHIFT.
  - start=0 stays in IDLE.
- SHIFT, one iteration per edge:
  - Every work digit >=5 gets +3, in parallel, then {digits, shift_reg} shifts left 1.
  - The bit shifted out of the top digit ORs into the sticky overflow bit.
  - The counter increments each iteration.
  - On the edge completing iteration W: load bcd from the work digits and overflow from the sticky bit, then move to DONE.
- DONE: done=1 for exactly this cycle; the next edge moves to IDLE unconditionally.
- Latency: start accepted at edge t0 -> done high in the cycle after edge t0+W, i.e. W cycles after acceptance.
- Throughput: one conversion per W+2 cycles.
- busy = (state != IDLE), so busy is high in both SHIFT and DONE.
- start while busy=1, including in DONE, is ignored and not queued. bin changes while busy have no effect.
- bcd and overflow change only on the completion edge or on reset. They are stable between conversions.
- Arithmetic per digit is 4-bit. Add-3 is applied only to values 5..9, so a corrected digit never exceeds 12 before the shift.
- No X propagation: every register has a defined reset value.

Decomposition:
- Package bcd_pkg holds:
  - typedef bcd_digit_t (logic [3:0])
  - constant BCD_ADJ_THRESH = 4'd5
  - constant BCD_ADJ_ADD = 4'd3
  - state enum bin2bcd_state_t {IDLE, SHIFT, DONE}
- One natural sub-module: bcd_digit_adj, combinational, bcd_digit_t in -> bcd_digit_t out (+3 if >=5). It is instantiated D times via generate.
- FSM, counter, and shift datapath stay in bin2bcd_seq.

Test Plan:
- W=8, D=3, bin=8'd255, start pulse -> done exactly 8 cycles after acceptance, bcd=12'h255, overflow=0, busy low the cycle after done.
- bin=0 -> bcd=12'h000, overflow=0; bin=8'd99 with a second start (bin=8'd200) pulsed 3 cycles into SHIFT -> single done, bcd=12'h099.
- Start bin=8'd173, assert reset on the 4th SHIFT cycle -> no done, bcd=0, busy=0; then start bin=8'd123 -> bcd=12'h123.
- W=8, D=2: bin=8'd150 -> bcd=8'h50, overflow=1; next conversion bin=8'd99 -> bcd=8'h99, overflow=0 (sticky bit cleared on load).
- Exhaustive sweep bin=0..255 (W=8, D=3) vs a behavioural model: bcd correct, done latency fixed at W, bcd stable between done pulses.
- Feed two results into the BCD adder (bin=8'd47 and 8'd38, taking low two digits) -> adder sum 8'h85, cout=0.
